mem_responder: RTL and testbench

- Memory-side responder for the CPU core's two memory ports.
- Port 1 returns the instruction at the CPU's PC; port 2 serves LDR reads and STR writes.
- Owns program loading: holds the CPU in reset, accepts a valid/ready word stream into RAM, then releases the CPU at the load base address.
- Optionally detects a halted CPU through its waiting output.

---
 rtl/mem_resp_pkg.sv | 20 ++
 rtl/mem_resp_dpram.sv | 61 ++++++
 rtl/mem_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg: shared types and widths for the memory responder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_resp_pkg;

  localparam int MEM_RESP_ADDR_W = 11;
  localparam int MEM_RESP_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } mem_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_resp_dpram.sv
// ---------------------------------------------------------------------------
// mem_resp_dpram: true dual-port RAM, registered read-first outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_resp_dpram
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = MEM_RESP_ADDR_W,
  parameter int DATA_W = MEM_RESP_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_rd_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_rd_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  // Storage is deliberately not reset so a loaded image survives rst.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // Disabled read ports return zero rather than holding stale data.
  always_comb begin
    a_rdata_d = '0;
    b_rdata_d = '0;
    if (a_rd_en) a_rdata_d = mem[a_addr];
    if (b_rd_en) b_rdata_d = mem[b_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder: CPU fetch/data memory with program loader. Rev 1.0
// Optional halt detection enabled by defining MEM_RESP_HALT_DETECT_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = MEM_RESP_ADDR_W,
  parameter int DATA_W      = MEM_RESP_DATA_W,
  parameter int HALT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] cpu_start_pc,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [DATA_W-1:0] cpu_instr,
  input  logic              cpu_w_en1,
  input  logic [ADDR_W-1:0] cpu_addr2,
  input  logic [DATA_W-1:0] cpu_wdata2,
  input  logic              cpu_w_en2,
  output logic [DATA_W-1:0] cpu_rdata2,
  input  logic              cpu_waiting,
  output logic [1:0]        state_out,
  output logic [ADDR_W-1:0] ld_count,
  output logic              halted,
  output logic              err_wen1
);

  mem_resp_state_t   state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic [ADDR_W-1:0] ld_count_q, ld_count_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              ld_ready_q, ld_ready_d;
  logic              err_q, err_d;
  logic              ld_fire;
  logic              cur_active, nxt_active;
  logic              halt_hit;

  assign ld_fire    = ld_valid && ld_ready_q;
  assign cur_active = (state_q == ST_RUN) || (state_q == ST_HALTED);
  assign nxt_active = (state_d == ST_RUN) || (state_d == ST_HALTED);

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    start_pc_d = start_pc_q;
    ld_count_d = ld_count_q;
    err_d      = err_q;

    if ((state_q == ST_RUN) && cpu_w_en1) err_d = 1'b1;

    if (start && (state_q != ST_LOAD)) begin
      state_d    = ST_LOAD;
      wr_addr_d  = ld_base;
      start_pc_d = ld_base;
      ld_count_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_fire) begin
            // Write pointer keeps wrapping even after the count saturates.
            wr_addr_d = wr_addr_q + 1'b1;
            if (ld_count_q != '1) ld_count_d = ld_count_q + 1'b1;
            if (ld_last) state_d = ST_RUN;
          end
        end
        ST_RUN:    if (halt_hit) state_d = ST_HALTED;
        ST_IDLE,
        ST_HALTED: state_d = state_q;
        default:   state_d = ST_IDLE;
      endcase
    end

    cpu_rst_n_d = nxt_active;
    ld_ready_d  = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      start_pc_q  <= '0;
      ld_count_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      start_pc_q  <= start_pc_d;
      ld_count_q  <= ld_count_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      ld_ready_q  <= ld_ready_d;
      err_q       <= err_d;
    end
  end

`ifdef MEM_RESP_HALT_DETECT_EN
  localparam int CNT_W = $clog2(HALT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             halted_q, halted_d;

  assign halt_hit = cpu_waiting && (wait_cnt_q == CNT_W'(HALT_CYCLES - 1));

  // Counter is only live while staying in RUN, so it restarts on every entry.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && cpu_waiting)
      wait_cnt_d = wait_cnt_q + 1'b1;
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  logic halt_unused;

  assign halt_unused = cpu_waiting ^ HALT_CYCLES[0];
  assign halt_hit    = 1'b0;
  assign halted      = 1'b0;
`endif

  // Port A is the loader write during LOAD and the instruction fetch otherwise.
  mem_resp_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_rd_en (cur_active && nxt_active),
    .a_we    (ld_fire),
    .a_addr  ((state_q == ST_LOAD) ? wr_addr_q : cpu_pc),
    .a_wdata (ld_data),
    .a_rdata (cpu_instr),
    .b_rd_en (cur_active && nxt_active),
    .b_we    (cpu_w_en2 && cur_active),
    .b_addr  (cpu_addr2),
    .b_wdata (cpu_wdata2),
    .b_rdata (cpu_rdata2)
  );

  assign state_out    = state_q;
  assign ld_ready     = ld_ready_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign cpu_start_pc = start_pc_q;
  assign ld_count     = ld_count_q;
  assign err_wen1     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder: scoreboard bench for mem_responder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int HC    = 16;
  localparam int DEPTH = 2048;

  localparam int S_INSTR  = 0;
  localparam int S_RDATA2 = 1;
  localparam int S_STATE  = 2;
  localparam int S_RSTN   = 3;
  localparam int S_READY  = 4;
  localparam int S_COUNT  = 5;
  localparam int S_SPC    = 6;
  localparam int S_HALTED = 7;
  localparam int S_ERR    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          cpu_rst_n;
  logic [AW-1:0] cpu_start_pc;
  logic [AW-1:0] cpu_pc;
  logic [DW-1:0] cpu_instr;
  logic          cpu_w_en1;
  logic [AW-1:0] cpu_addr2;
  logic [DW-1:0] cpu_wdata2;
  logic          cpu_w_en2;
  logic [DW-1:0] cpu_rdata2;
  logic          cpu_waiting;
  logic [1:0]    state_out;
  logic [AW-1:0] ld_count;
  logic          halted;
  logic          err_wen1;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .HALT_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_rst_n(cpu_rst_n), .cpu_start_pc(cpu_start_pc), .cpu_pc(cpu_pc),
    .cpu_instr(cpu_instr), .cpu_w_en1(cpu_w_en1), .cpu_addr2(cpu_addr2),
    .cpu_wdata2(cpu_wdata2), .cpu_w_en2(cpu_w_en2), .cpu_rdata2(cpu_rdata2),
    .cpu_waiting(cpu_waiting), .state_out(state_out), .ld_count(ld_count),
    .halted(halted), .err_wen1(err_wen1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model: memory image plus abstract controller state.
  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];
  int          m_state  = 0;
  bit          m_err    = 1'b0;
  int          m_count  = 0;
  int          wait_run = 0;
  logic [31:0] wq[$];

  function automatic string sel_name(input int sel);
    case (sel)
      S_INSTR:  return "cpu_instr";
      S_RDATA2: return "cpu_rdata2";
      S_STATE:  return "state_out";
      S_RSTN:   return "cpu_rst_n";
      S_READY:  return "ld_ready";
      S_COUNT:  return "ld_count";
      S_SPC:    return "cpu_start_pc";
      S_HALTED: return "halted";
      S_ERR:    return "err_wen1";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_INSTR:  return cpu_instr;
      S_RDATA2: return cpu_rdata2;
      S_STATE:  return {30'd0, state_out};
      S_RSTN:   return {31'd0, cpu_rst_n};
      S_READY:  return {31'd0, ld_ready};
      S_COUNT:  return {21'd0, ld_count};
      S_SPC:    return {21'd0, cpu_start_pc};
      S_HALTED: return {31'd0, halted};
      S_ERR:    return {31'd0, err_wen1};
      default:  return '0;
    endcase
  endfunction

  // Monitor: compares every expectation whose cycle has arrived.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e   = sbq.pop_front();
      act = actual(e.sel);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s cycle=%0d actual=%h required=%h", sel_name(e.sel), cyc, act, e.exp);
      end
    end
  end

  task automatic push(input int due, input int sel, input logic [31:0] v);
    exp_t e;
    e.due = due; e.sel = sel; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic expect_now(input int sel, input logic [31:0] v);
    push(cyc, sel, v);
  endtask

  task automatic expect_next(input int sel, input logic [31:0] v);
    push(cyc + 1, sel, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int n);
    return (n > DEPTH - 1) ? DEPTH - 1 : n;
  endfunction

  task automatic do_load(input logic [AW-1:0] base, input int n, input int abort_after, input bit gaps);
    int          sent;
    logic [31:0] w;
    logic [AW-1:0] a;
    sent = 0;
    cpu_w_en1 = 1'b0; cpu_w_en2 = 1'b0; cpu_waiting = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    start = 1'b1; ld_base = base;
    expect_next(S_STATE, 1); expect_next(S_RSTN, 0); expect_next(S_READY, 1);
    expect_next(S_COUNT, 0); expect_next(S_SPC, {21'd0, base}); expect_next(S_HALTED, 0);
    tick();
    start = 1'b0;
    while (sent < n) begin
      if (abort_after >= 0 && sent == abort_after) begin
        ld_valid = 1'b0; rst = 1'b1;
        m_state = 0; m_err = 1'b0; m_count = 0;
        expect_now(S_STATE, 0); expect_now(S_RSTN, 0); expect_now(S_READY, 0);
        expect_now(S_COUNT, 0); expect_now(S_SPC, 0); expect_now(S_INSTR, 0);
        expect_now(S_RDATA2, 0); expect_now(S_ERR, 0);
        tick();
        rst = 1'b0;
        return;
      end
      expect_now(S_STATE, 1); expect_now(S_READY, 1); expect_now(S_RSTN, 0);
      expect_now(S_COUNT, sat(sent)); expect_now(S_SPC, {21'd0, base});
      expect_now(S_INSTR, 0); expect_now(S_RDATA2, 0); expect_now(S_ERR, {31'd0, m_err});
      // Noise that must have no effect while loading.
      start      = gaps && ($urandom_range(0, 7) == 0);
      ld_base    = AW'($urandom);
      cpu_w_en2  = 1'($urandom_range(0, 1));
      cpu_addr2  = AW'($urandom);
      cpu_wdata2 = $urandom;
      cpu_w_en1  = ($urandom_range(0, 3) == 0);
      ld_valid   = !gaps || ($urandom_range(0, 3) != 0);
      if (ld_valid) begin
        w = (wq.size() > 0) ? wq.pop_front() : $urandom;
        a = AW'(base + AW'(sent));
        ld_data = w; ld_last = (sent == n - 1);
        ref_mem[a] = w; known[a] = 1'b1;
        sent++;
      end else begin
        ld_data = $urandom; ld_last = 1'($urandom_range(0, 1));
      end
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0; cpu_w_en1 = 1'b0; cpu_w_en2 = 1'b0;
    m_state = 2; m_count = sat(n); wait_run = 0;
    expect_now(S_STATE, 2); expect_now(S_RSTN, 1); expect_now(S_READY, 0);
    expect_now(S_COUNT, m_count); expect_now(S_SPC, {21'd0, base});
    expect_now(S_INSTR, 0); expect_now(S_RDATA2, 0); expect_now(S_HALTED, 0);
  endtask

  task automatic run_cycle(input logic [AW-1:0] pc, input logic [AW-1:0] a2, input bit we,
                           input logic [31:0] wd, input bit wen1, input bit waiting);
    cpu_pc = pc; cpu_addr2 = a2; cpu_w_en2 = we; cpu_wdata2 = wd;
    cpu_w_en1 = wen1; cpu_waiting = waiting;
    ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom; ld_last = 1'($urandom_range(0, 1));
    expect_now(S_STATE, m_state); expect_now(S_RSTN, 1); expect_now(S_READY, 0);
    expect_now(S_COUNT, m_count); expect_now(S_ERR, {31'd0, m_err});
    expect_now(S_HALTED, {31'd0, (m_state == 3)});
    if (wen1 && m_state == 2) m_err = 1'b1;
`ifdef MEM_RESP_HALT_DETECT_EN
    if (m_state == 2) begin
      wait_run = waiting ? wait_run + 1 : 0;
      if (wait_run >= HC) m_state = 3;
    end
`endif
    if (known[pc]) expect_next(S_INSTR, ref_mem[pc]);
    if (known[a2]) expect_next(S_RDATA2, ref_mem[a2]);
    if (we) begin
      ref_mem[a2] = wd; known[a2] = 1'b1;
    end
    tick();
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] p;
      logic [AW-1:0] a;
      p = AW'($urandom);
      a = ($urandom_range(0, 3) == 0) ? p : AW'($urandom);
      run_cycle(p, a, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    cpu_pc = '0; cpu_w_en1 = 1'b0; cpu_addr2 = '0; cpu_wdata2 = '0; cpu_w_en2 = 1'b0;
    cpu_waiting = 1'b0;
    tick(); tick();
    for (int s = S_INSTR; s <= S_ERR; s++) expect_now(s, 0);
    tick();
    rst = 1'b0;
    tick();
    expect_now(S_STATE, 0); expect_now(S_RSTN, 0); expect_now(S_READY, 0);
    tick();

    // Small image at 0x010, then fetch from its middle.
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_load(11'h010, 4, -1, 1'b0);
    run_cycle(11'h012, 11'h010, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_cycle(AW'(11'h010 + i), AW'(11'h013 - i), 1'b0, 32'h0, 1'b0, 1'b0);

    // Over-long image: count saturates and the pointer wraps onto the base.
    do_load(11'h400, 2050, -1, 1'b1);
    run_cycle(11'h400, 11'h401, 1'b0, 32'h0, 1'b0, 1'b0);

    // Read-first collisions on both ports.
    run_cycle(11'h100, 11'h100, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    run_cycle(11'h100, 11'h100, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    run_cycle(11'h100, 11'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    rand_run(200);

    run_cycle(11'h005, 11'h006, 1'b0, 32'h0, 1'b1, 1'b0);
    run_cycle(11'h007, 11'h008, 1'b0, 32'h0, 1'b0, 1'b0);

    // Load across the top of the address space.
    wq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    do_load(11'h7FE, 4, -1, 1'b1);
    run_cycle(11'h7FE, 11'h000, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cycle(11'h7FF, 11'h001, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cycle(11'h000, 11'h002, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cycle(11'h001, 11'h7FD, 1'b0, 32'h0, 1'b0, 1'b0);
    rand_run(100);

    // Reset in the middle of a load keeps the words already written.
    do_load(11'h300, 5, 2, 1'b0);
    do_load(11'h050, 1, -1, 1'b0);
    run_cycle(11'h300, 11'h301, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cycle(11'h302, 11'h050, 1'b0, 32'h0, 1'b0, 1'b0);

    // Waiting just short of the limit, a break, then the full limit.
    for (int i = 0; i < HC - 1; i++) run_cycle(AW'(i), AW'(i + 1), 1'b0, 32'h0, 1'b0, 1'b1);
    run_cycle(11'h020, 11'h021, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < HC; i++) run_cycle(AW'(i + 8), AW'(i + 9), 1'b0, 32'h0, 1'b0, 1'b1);
    run_cycle(11'h030, 11'h031, 1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    run_cycle(11'h031, 11'h030, 1'b0, 32'h0, 1'b0, 1'b0);
    do_load(11'h020, 2, -1, 1'b0);
    run_cycle(11'h020, 11'h021, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cycle(11'h031, 11'h400, 1'b0, 32'h0, 1'b0, 1'b0);

    cpu_w_en1 = 1'b0; cpu_w_en2 = 1'b0; ld_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
